// File: rtl/axi4_master_pkg.sv
// -----------------------------------------------------------------------------
// axi4_master_pkg
// Shared types and helpers for the AXI4 memory master:
//   - state_e      : transaction FSM states
//   - SZ_*         : request size encodings (byte/half/word/dword)
//   - LANE_DATA_W  : data bus width handled by the lane aligner
//   - NUM_LANES    : byte lanes on the data bus
//   - strb_mask()  : byte-strobe pattern for a size at a lane offset
//   - misaligned() : true when an offset is not a multiple of the access size
// -----------------------------------------------------------------------------
package axi4_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_WR,
        ST_B,
        ST_RESP
    } state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam int LANE_DATA_W = 64;
    localparam int NUM_LANES   = LANE_DATA_W / 8;

    // Contiguous run of 2^size ones, shifted up to the starting lane.
    function automatic logic [NUM_LANES-1:0] strb_mask(input logic [1:0] size,
                                                        input logic [2:0] off);
        logic [NUM_LANES-1:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    // Any offset bit below the access size makes the access misaligned.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [2:0] off);
        logic [2:0] low_mask;
        case (size)
            SZ_B:    low_mask = 3'b000;
            SZ_H:    low_mask = 3'b001;
            SZ_W:    low_mask = 3'b011;
            default: low_mask = 3'b111;
        endcase
        return |(off & low_mask);
    endfunction

endpackage

// File: rtl/axi4_lane_align.sv
// -----------------------------------------------------------------------------
// axi4_lane_align
// Combinational byte-lane steering for both directions.
//   off_i      : byte offset within the 64-bit beat (addr[2:0])
//   size_i     : access size (SZ_B/H/W/D)
//   signed_i   : sign-extend load result (ignored for dword)
//   st_data_i  : right-justified store data
//   ld_data_i  : raw read beat from the bus
//   st_data_o  : store data shifted into its lanes
//   st_strb_o  : byte strobes for the store
//   ld_data_o  : load data shifted down and extended to 64 bits
// -----------------------------------------------------------------------------
module axi4_lane_align
    import axi4_master_pkg::*;
(
    input  logic [2:0]             off_i,
    input  logic [1:0]             size_i,
    input  logic                   signed_i,
    input  logic [LANE_DATA_W-1:0] st_data_i,
    input  logic [LANE_DATA_W-1:0] ld_data_i,
    output logic [LANE_DATA_W-1:0] st_data_o,
    output logic [NUM_LANES-1:0]   st_strb_o,
    output logic [LANE_DATA_W-1:0] ld_data_o
);

    logic [5:0]             shamt;
    logic [LANE_DATA_W-1:0] ld_shift;

    assign shamt = {off_i, 3'b000};

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; an unassigned path would infer a latch.
        st_data_o = st_data_i << shamt;
        st_strb_o = strb_mask(size_i, off_i);
        ld_shift  = ld_data_i >> shamt;
        ld_data_o = ld_shift;
        case (size_i)
            SZ_B: ld_data_o = {{56{signed_i & ld_shift[7]}},  ld_shift[7:0]};
            SZ_H: ld_data_o = {{48{signed_i & ld_shift[15]}}, ld_shift[15:0]};
            SZ_W: ld_data_o = {{32{signed_i & ld_shift[31]}}, ld_shift[31:0]};
            default: ;  // dword: full beat, no extension
        endcase
    end

endmodule

// File: rtl/axi4_mem_master.sv
// -----------------------------------------------------------------------------
// axi4_mem_master
// Turns single core load/store requests into one AXI4 read (AR/R) or write
// (AW/W/B) transaction at a time. Handles lane alignment, strobes, load
// extension, misalignment rejection and write-response timeout.
//   clock, reset         : rising-edge clock, async active-low reset
//   io_req_*             : core request (valid/ready handshake)
//   io_resp_*            : one-cycle completion pulse with data and error
//   io_ar*, io_rdata     : read address channel; data arrives the cycle after
//                          the AR handshake
//   io_aw*, io_w*        : write address and data channels
//   io_bvalid            : write response pulse (always accepted)
// All AXI-facing outputs are registered. Only DATA_W = 64 is supported.
// -----------------------------------------------------------------------------
module axi4_mem_master
    import axi4_master_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int B_TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_req_valid,
    output logic              io_req_ready,
    input  logic              io_req_wen,
    input  logic [ADDR_W-1:0] io_req_addr,
    input  logic [1:0]        io_req_size,
    input  logic              io_req_signed,
    input  logic [DATA_W-1:0] io_req_wdata,
    output logic              io_resp_valid,
    output logic [DATA_W-1:0] io_resp_rdata,
    output logic              io_resp_err,
    output logic [ADDR_W-1:0] io_awaddr,
    output logic              io_awvalid,
    input  logic              io_awready,
    output logic [ADDR_W-1:0] io_araddr,
    output logic              io_arvalid,
    input  logic              io_arready,
    input  logic [DATA_W-1:0] io_rdata,
    output logic [DATA_W-1:0] io_wdata,
    output logic [7:0]        io_wstrb,
    output logic              io_wvalid,
    input  logic              io_wready,
    input  logic              io_bvalid
);

    localparam logic [7:0] B_LAST = 8'(B_TIMEOUT - 1);

    state_e            state_q;
    logic [2:0]        off_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic              aw_done_q, w_done_q;
    logic [7:0]        b_cnt_q;

    logic              req_ready_q, resp_valid_q, resp_err_q;
    logic [DATA_W-1:0] resp_rdata_q, wdata_q;
    logic [ADDR_W-1:0] awaddr_q, araddr_q;
    logic              awvalid_q, arvalid_q, wvalid_q;
    logic [7:0]        wstrb_q;

    // Single aligner: fed from the live request while idle (store setup at
    // acceptance) and from the latched request afterwards (load extraction).
    logic              in_idle;
    logic [2:0]        al_off;
    logic [1:0]        al_size;
    logic [DATA_W-1:0] al_wdata, al_rdata;
    logic [7:0]        al_strb;

    assign in_idle = (state_q == ST_IDLE);
    assign al_off  = in_idle ? io_req_addr[2:0] : off_q;
    assign al_size = in_idle ? io_req_size      : size_q;

    axi4_lane_align u_align (
        .off_i     (al_off),
        .size_i    (al_size),
        .signed_i  (signed_q),
        .st_data_i (io_req_wdata),
        .ld_data_i (io_rdata),
        .st_data_o (al_wdata),
        .st_strb_o (al_strb),
        .ld_data_o (al_rdata)
    );

    // A channel counts as finished once handshaken earlier or handshaking now.
    logic aw_fin, w_fin;
    assign aw_fin = aw_done_q | io_awready;
    assign w_fin  = w_done_q  | io_wready;

    logic [ADDR_W-1:0] beat_addr;
    assign beat_addr = {io_req_addr[ADDR_W-1:3], 3'b000};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            off_q        <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            b_cnt_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            awaddr_q     <= '0;
            awvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            wvalid_q     <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments only, so every
            // register samples the pre-edge values regardless of statement order.
            resp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (io_req_valid) begin
                        off_q       <= io_req_addr[2:0];
                        size_q      <= io_req_size;
                        signed_q    <= io_req_signed;
                        req_ready_q <= 1'b0;
                        if (misaligned(io_req_size, io_req_addr[2:0])) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (io_req_wen) begin
                            state_q   <= ST_WR;
                            awaddr_q  <= beat_addr;
                            awvalid_q <= 1'b1;
                            wdata_q   <= al_wdata;
                            wstrb_q   <= al_strb;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                        end else begin
                            state_q   <= ST_AR;
                            araddr_q  <= beat_addr;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                ST_AR: begin
                    if (io_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= ST_R;
                    end
                end
                ST_R: begin
                    resp_rdata_q <= al_rdata;
                    resp_err_q   <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_WR: begin
                    if (io_awready && !aw_done_q) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (io_wready && !w_done_q) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        b_cnt_q <= '0;
                        state_q <= ST_B;
                    end
                end
                ST_B: begin
                    if (io_bvalid || b_cnt_q == B_LAST) begin
                        resp_err_q   <= !io_bvalid;
                        resp_rdata_q <= '0;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        b_cnt_q <= b_cnt_q + 8'd1;
                    end
                end
                ST_RESP: begin
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign io_req_ready  = req_ready_q;
    assign io_resp_valid = resp_valid_q;
    assign io_resp_rdata = resp_rdata_q;
    assign io_resp_err   = resp_err_q;
    assign io_awaddr     = awaddr_q;
    assign io_awvalid    = awvalid_q;
    assign io_araddr     = araddr_q;
    assign io_arvalid    = arvalid_q;
    assign io_wdata      = wdata_q;
    assign io_wstrb      = wstrb_q;
    assign io_wvalid     = wvalid_q;

endmodule

// File: tb/tb_axi4_mem_master.sv
// -----------------------------------------------------------------------------
// tb_axi4_mem_master
// Directed, table-driven bench for axi4_mem_master plus hand-written sequences
// for delayed AW handshake, write-response timeout and mid-transaction reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_axi4_mem_master;

    logic        clock;
    logic        reset;
    logic        io_req_valid;
    logic        io_req_ready;
    logic        io_req_wen;
    logic [63:0] io_req_addr;
    logic [1:0]  io_req_size;
    logic        io_req_signed;
    logic [63:0] io_req_wdata;
    logic        io_resp_valid;
    logic [63:0] io_resp_rdata;
    logic        io_resp_err;
    logic [63:0] io_awaddr;
    logic        io_awvalid;
    logic        io_awready;
    logic [63:0] io_araddr;
    logic        io_arvalid;
    logic        io_arready;
    logic [63:0] io_rdata;
    logic [63:0] io_wdata;
    logic [7:0]  io_wstrb;
    logic        io_wvalid;
    logic        io_wready;
    logic        io_bvalid;

    axi4_mem_master dut (
        .clock         (clock),
        .reset         (reset),
        .io_req_valid  (io_req_valid),
        .io_req_ready  (io_req_ready),
        .io_req_wen    (io_req_wen),
        .io_req_addr   (io_req_addr),
        .io_req_size   (io_req_size),
        .io_req_signed (io_req_signed),
        .io_req_wdata  (io_req_wdata),
        .io_resp_valid (io_resp_valid),
        .io_resp_rdata (io_resp_rdata),
        .io_resp_err   (io_resp_err),
        .io_awaddr     (io_awaddr),
        .io_awvalid    (io_awvalid),
        .io_awready    (io_awready),
        .io_araddr     (io_araddr),
        .io_arvalid    (io_arvalid),
        .io_arready    (io_arready),
        .io_rdata      (io_rdata),
        .io_wdata      (io_wdata),
        .io_wstrb      (io_wstrb),
        .io_wvalid     (io_wvalid),
        .io_wready     (io_wready),
        .io_bvalid     (io_bvalid)
    );

    localparam int B_TIMEOUT = 255;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        mis;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_strb;
        logic [63:0] exp_rdata;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic drive_req(input vec_t v);
        io_req_valid  = 1'b1;
        io_req_wen    = v.wen;
        io_req_addr   = v.addr;
        io_req_size   = v.size;
        io_req_signed = v.sgn;
        io_req_wdata  = v.wdata;
    endtask

    // Zero-wait transaction; cycle 1 is the cycle after the accepting edge.
    task automatic run_vec(input int id, input vec_t v);
        check($sformatf("v%0d req_ready idle", id), io_req_ready, 1);
        drive_req(v);
        step();
        io_req_valid = 1'b0;
        if (v.mis) begin
            check($sformatf("v%0d no arvalid", id), io_arvalid, 0);
            check($sformatf("v%0d no awvalid", id), io_awvalid, 0);
        end else if (!v.wen) begin
            check($sformatf("v%0d arvalid c1", id), io_arvalid, 1);
            check($sformatf("v%0d araddr", id), io_araddr, v.exp_addr);
            step();
            io_rdata = v.rdata;
            check($sformatf("v%0d arvalid c2", id), io_arvalid, 0);
            check($sformatf("v%0d resp early", id), io_resp_valid, 0);
            step();
            io_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        end else begin
            check($sformatf("v%0d awvalid c1", id), io_awvalid, 1);
            check($sformatf("v%0d wvalid c1", id), io_wvalid, 1);
            check($sformatf("v%0d awaddr", id), io_awaddr, v.exp_addr);
            check($sformatf("v%0d wdata", id), io_wdata, v.exp_wdata);
            check($sformatf("v%0d wstrb", id), io_wstrb, v.exp_strb);
            step();
            check($sformatf("v%0d awvalid c2", id), io_awvalid, 0);
            check($sformatf("v%0d wvalid c2", id), io_wvalid, 0);
            io_bvalid = 1'b1;
            step();
            io_bvalid = 1'b0;
        end
        check($sformatf("v%0d resp_valid", id), io_resp_valid, 1);
        check($sformatf("v%0d resp_err", id), io_resp_err, v.mis);
        check($sformatf("v%0d resp_rdata", id), io_resp_rdata, v.exp_rdata);
        check($sformatf("v%0d req_ready in resp", id), io_req_ready, 0);
        step();
        check($sformatf("v%0d resp pulse width", id), io_resp_valid, 0);
        check($sformatf("v%0d req_ready after", id), io_req_ready, 1);
    endtask

    initial begin
        int lat;
        logic seen;

        //          wen addr          sz sg wdata                  rdata                  mis exp_addr      exp_wdata              strb   exp_rdata
        vecs[0]  = '{0, 64'h80000010, 3, 0, 64'h0,                 64'h1122334455667788, 0, 64'h80000010, 64'h0,                 8'h00, 64'h1122334455667788};
        vecs[1]  = '{0, 64'h80000003, 0, 1, 64'h0,                 64'h0000000080FF0000, 0, 64'h80000000, 64'h0,                 8'h00, 64'hFFFFFFFFFFFFFF80};
        vecs[2]  = '{0, 64'h80000003, 0, 0, 64'h0,                 64'h0000000080FF0000, 0, 64'h80000000, 64'h0,                 8'h00, 64'h0000000000000080};
        vecs[3]  = '{0, 64'h80000006, 1, 1, 64'h0,                 64'h8001000000000000, 0, 64'h80000000, 64'h0,                 8'h00, 64'hFFFFFFFFFFFF8001};
        vecs[4]  = '{0, 64'h80000004, 2, 0, 64'h0,                 64'hCAFEBABE12345678, 0, 64'h80000000, 64'h0,                 8'h00, 64'h00000000CAFEBABE};
        vecs[5]  = '{0, 64'h80000004, 2, 1, 64'h0,                 64'hCAFEBABE12345678, 0, 64'h80000000, 64'h0,                 8'h00, 64'hFFFFFFFFCAFEBABE};
        vecs[6]  = '{0, 64'h80000008, 3, 1, 64'h0,                 64'h8000000000000001, 0, 64'h80000008, 64'h0,                 8'h00, 64'h8000000000000001};
        vecs[7]  = '{1, 64'h80000006, 1, 0, 64'h000000000000BEEF, 64'h0,                 0, 64'h80000000, 64'hBEEF000000000000, 8'hC0, 64'h0};
        vecs[8]  = '{1, 64'h80000001, 0, 0, 64'h00000000000000A5, 64'h0,                 0, 64'h80000000, 64'h000000000000A500, 8'h02, 64'h0};
        vecs[9]  = '{1, 64'h80000004, 2, 0, 64'h00000000DEADBEEF, 64'h0,                 0, 64'h80000000, 64'hDEADBEEF00000000, 8'hF0, 64'h0};
        vecs[10] = '{1, 64'h80000008, 3, 0, 64'h0123456789ABCDEF, 64'h0,                 0, 64'h80000008, 64'h0123456789ABCDEF, 8'hFF, 64'h0};
        vecs[11] = '{0, 64'h80000002, 2, 0, 64'h0,                 64'h0,                 1, 64'h0,        64'h0,                 8'h00, 64'h0};
        vecs[12] = '{1, 64'h80000001, 1, 0, 64'h1234,              64'h0,                 1, 64'h0,        64'h0,                 8'h00, 64'h0};

        reset         = 1'b0;
        io_req_valid  = 1'b0;
        io_req_wen    = 1'b0;
        io_req_addr   = '0;
        io_req_size   = '0;
        io_req_signed = 1'b0;
        io_req_wdata  = '0;
        io_awready    = 1'b1;
        io_arready    = 1'b1;
        io_wready     = 1'b1;
        io_rdata      = '0;
        io_bvalid     = 1'b0;

        // Reset state
        step();
        step();
        check("rst req_ready", io_req_ready, 1);
        check("rst resp_valid", io_resp_valid, 0);
        check("rst resp_err", io_resp_err, 0);
        check("rst resp_rdata", io_resp_rdata, 0);
        check("rst arvalid", io_arvalid, 0);
        check("rst awvalid", io_awvalid, 0);
        check("rst wvalid", io_wvalid, 0);
        check("rst araddr", io_araddr, 0);
        check("rst awaddr", io_awaddr, 0);
        check("rst wdata", io_wdata, 0);
        check("rst wstrb", io_wstrb, 0);
        reset = 1'b1;
        step();

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Half store with AW ready delayed: W handshakes at edge 1, AW at edge 4.
        io_awready = 1'b0;
        drive_req(vecs[7]);
        step();
        io_req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("dly awvalid c%0d", c), io_awvalid, 1);
            check($sformatf("dly awaddr c%0d", c), io_awaddr, 64'h80000000);
            check($sformatf("dly wvalid c%0d", c), io_wvalid, (c == 1) ? 1 : 0);
            check($sformatf("dly wdata c%0d", c), io_wdata, 64'hBEEF000000000000);
            check($sformatf("dly wstrb c%0d", c), io_wstrb, 8'hC0);
            check($sformatf("dly resp c%0d", c), io_resp_valid, 0);
            io_bvalid  = (c == 2);   // stray response while still in WR
            io_awready = (c == 4);
            step();
        end
        io_awready = 1'b1;
        io_bvalid  = 1'b0;
        check("dly awvalid dropped", io_awvalid, 0);
        check("dly resp before b", io_resp_valid, 0);
        io_bvalid = 1'b1;
        step();
        io_bvalid = 1'b0;
        check("dly resp_valid", io_resp_valid, 1);
        check("dly resp_err", io_resp_err, 0);
        step();

        // Write response never arrives: timeout error, then normal operation.
        drive_req(vecs[9]);
        step();
        io_req_valid = 1'b0;
        lat = 1;
        while (!io_resp_valid && lat < 400) begin
            step();
            lat++;
        end
        tests++;
        if (lat < B_TIMEOUT + 1 || lat > B_TIMEOUT + 3) begin
            fails++;
            $display("FAIL b_timeout latency: got %0d cycles, expected %0d..%0d",
                     lat, B_TIMEOUT + 1, B_TIMEOUT + 3);
        end
        check("timeout resp_err", io_resp_err, 1);
        check("timeout resp_rdata", io_resp_rdata, 0);
        step();
        run_vec(100, vecs[0]);

        // Reset mid-AR with arready low: outputs clear at once, no response.
        io_arready = 1'b0;
        drive_req(vecs[4]);
        step();
        io_req_valid = 1'b0;
        check("rstmid arvalid before", io_arvalid, 1);
        #3;
        reset = 1'b0;
        #1;
        check("rstmid arvalid", io_arvalid, 0);
        check("rstmid araddr", io_araddr, 0);
        check("rstmid req_ready", io_req_ready, 1);
        step();
        reset      = 1'b1;
        io_arready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            seen |= io_resp_valid | io_arvalid;
            step();
        end
        check("rstmid no activity", seen, 0);
        check("rstmid req_ready after", io_req_ready, 1);
        run_vec(101, vecs[5]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axi4_mem_master.md
# axi4_mem_master

Initiator side of the simplified AXI4 memory interface: converts single load/store requests from the core's memory stage into AR/R or AW/W/B transactions toward the AXI4 RAM responder. Handles one outstanding transaction, performs byte-lane alignment, strobe generation and load extension, and detects misaligned accesses and lost write responses.

## Interface
- ADDR_W, 64, address width of core request and AXI address channels
- DATA_W, 64, data bus width (8 byte lanes)
- B_TIMEOUT, 255, cycles to wait for io_bvalid before reporting an error

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low (asserted at 0)
- io_req_valid  in  1  core request present
- io_req_ready  out  1  block can accept a request
- io_req_wen  in  1  1 = store, 0 = load
- io_req_addr  in  ADDR_W  byte address
- io_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
- io_req_signed  in  1  sign-extend load result
- io_req_wdata  in  DATA_W  store data, right-justified
- io_resp_valid  out  1  one-cycle completion pulse
- io_resp_rdata  out  DATA_W  extended load data (0 for stores)
- io_resp_err  out  1  misaligned access or write-response timeout, valid with io_resp_valid
- io_awaddr  out  ADDR_W  write address, bits [2:0] forced to 0
- io_awvalid  out  1
- io_awready  in  1
- io_araddr  out  ADDR_W  read address, bits [2:0] forced to 0
- io_arvalid  out  1
- io_arready  in  1
- io_rdata  in  DATA_W  read data, valid the cycle after the AR handshake (no rvalid)
- io_wdata  out  DATA_W  lane-shifted store data
- io_wstrb  out  8  byte strobes
- io_wvalid  out  1
- io_wready  in  1
- io_bvalid  in  1  write response pulse (no bready; always accepted)

## Operation
- States: IDLE, AR, R, WR, B, RESP.
- IDLE: io_req_ready = 1. On io_req_valid: latch addr, size, signed, wdata. If addr not aligned to 2^size bytes -> RESP with err = 1, no bus activity. Else load -> AR, store -> WR.
- AR: io_arvalid = 1, io_araddr registered and stable; on io_arready -> R.
- R: capture io_rdata at the end of this cycle -> RESP.
- Load extraction: shift right by addr[2:0]*8, keep 8 << size bits, sign- or zero-extend per io_req_signed; size 3 ignores io_req_signed.
- WR: io_awvalid and io_wvalid both asserted; each drops independently after its own handshake (aw_done / w_done flags); both done (possibly in same cycle) -> B.
- Store: io_wdata = wdata << (addr[2:0]*8); io_wstrb = ((1 << (1 << size)) - 1) << addr[2:0].
- B: 8-bit counter from 0; on io_bvalid -> RESP, err = 0; counter reaching B_TIMEOUT -> RESP, err = 1.
- io_bvalid outside state B is ignored; io_rdata outside state R is ignored.
- RESP: io_resp_valid = 1 for exactly one cycle -> IDLE.

## Timing
- Reset values: io_req_ready = 1; every valid, io_resp_err, io_awaddr, io_araddr, io_wdata, io_wstrb and io_resp_rdata are 0; state IDLE, counter 0.
- Reset asserted mid-transaction: all outputs take reset values immediately (asynchronous); the in-flight transaction is abandoned and no response is produced.
- All AXI outputs are registered; no combinational path from any AXI input to any AXI output.
- Load, zero wait: accept at edge 0; AR during cycle 1; R in cycle 2; io_resp_valid in cycle 3; io_req_ready in cycle 4.
- Store, zero wait: accept at edge 0; AW+W in cycle 1; B from cycle 2; io_resp_valid the cycle after io_bvalid is seen.
- Misaligned: io_resp_valid with err = 1 in cycle 1.
- Once asserted, valid and payload hold until the handshake completes (AXI stability rule).

## Structure
- Package axi4_master_pkg: state enum, size encodings (SZ_B/H/W/D), data width and lane-count constants, strobe-mask function.
- Sub-module axi4_lane_align (combinational): store shift and strobe generation, load shift and extension. Shared by the FSM for both directions.

## Test plan
- Load dword at 0x80000010, arready = 1, RAM returns 0x1122334455667788 -> resp_rdata 0x1122334455667788, err 0, resp_valid in cycle 3.
- Signed byte load at 0x80000003, rdata 0x00000000_80FF0000 -> resp_rdata 0xFFFFFFFFFFFFFF80; same load unsigned -> 0x80.
- Half store 0xBEEF at 0x80000006, awready delayed 3 cycles, wready = 1 -> wvalid drops after cycle 1, awvalid held 4 cycles, awaddr 0x80000000, wstrb 0xC0, wdata 0xBEEF000000000000.
- Word load at 0x80000002 -> no arvalid, resp_valid with err 1 one cycle after acceptance.
- Store with io_bvalid never asserted -> resp_valid with err 1 after B_TIMEOUT cycles in B; next request accepted normally.
- reset driven low while in AR with arready = 0 -> arvalid drops immediately, no resp_valid; after release, req_ready = 1.
